// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier.
package mul_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MUL_W = 8;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    ADD    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mul_datapath.sv
// Datapath for the repeated-addition multiplier: multiplicand register,
// multiplier down-counter and product accumulator, steered by the controller.
module mul_datapath #(
  parameter int W = mul_pkg::MUL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   data_in,
  input  logic           ldA,
  input  logic           ldB,
  input  logic           clrP,
  input  logic           add,
  output logic           Bzero,
  output logic [2*W-1:0] product
);

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_p;

  // Operand capture, countdown and accumulation.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make the add see a half-updated counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      if (ldA) r_a <= data_in;
      if (ldB) r_b <= data_in;
      if (clrP) begin
        r_p <= '0;
      end else if (add) begin
        // A is zero-extended; (2^W-1)^2 always fits in 2W bits.
        r_p <= r_p + {{W{1'b0}}, r_a};
        r_b <= r_b - 1'b1;
      end
    end
  end

  assign Bzero   = (r_b == '0);
  assign product = r_p;

endmodule

// File: rtl/mul_ckt.sv
// Sequential repeated-addition multiplier: loads A then B over one bus,
// adds A once per cycle while counting B down, then strobes done.
module mul_ckt
  import mul_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   data_in,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_ld_a;
  logic   w_ld_b;
  logic   w_clr_p;
  logic   w_add;
  logic   w_b_zero;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD_B;
      LOAD_B:  w_state_nxt = ADD;
      ADD:     if (w_b_zero) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath strobes and status outputs, decoded from the state register.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    w_clr_p = 1'b0;
    w_add   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      IDLE: begin
        busy   = 1'b0;
        w_ld_a = start;
      end
      LOAD_B: begin
        w_ld_b  = 1'b1;
        w_clr_p = 1'b1;
      end
      ADD:     w_add = ~w_b_zero;
      DONE:    done  = 1'b1;
      default: busy  = 1'b0;
    endcase
  end

  mul_datapath #(.W(W)) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .ldA     (w_ld_a),
    .ldB     (w_ld_b),
    .clrP    (w_clr_p),
    .add     (w_add),
    .Bzero   (w_b_zero),
    .product (product)
  );

endmodule

// File: tb/tb_mul_ckt.sv
// Scoreboard bench for mul_ckt: the driver pushes the hand-computed product
// and the cycle in which done must appear; a monitor pops on every done.
module tb_mul_ckt;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] prod;
    int             done_cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   data_in = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  exp_t           sb[$];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  logic [2*W-1:0] prev_product = '0;
  bit             chk_done_low = 1'b0;

  mul_ckt #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to time done.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done strobe and checks the strobe is one cycle wide.
  always @(negedge clk) begin
    if (rst_n && chk_done_low) check("done_one_cycle", {31'd0, done}, 32'd0);
    chk_done_low = 1'b0;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", {16'd0, product}, {16'd0, e.prod});
        check("done_cycle", cyc, e.done_cyc);
        check("busy_in_done", {31'd0, busy}, 32'd1);
      end
      chk_done_low = 1'b1;
    end
  end

  // One full operation; inject pulses a stray start during ADD.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    exp_t e;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    data_in = a;
    @(posedge clk);                      // edge 1
    @(negedge clk);
    check("busy_after_e1", {31'd0, busy}, 32'd1);
    check("product_held", {16'd0, product}, {16'd0, prev_product});
    e.prod = 16'(a) * 16'(b);
    e.done_cyc = cyc + int'(b) + 2;
    sb.push_back(e);
    start = 1'b0;
    data_in = b;
    @(posedge clk);                      // edge 2
    @(negedge clk);
    data_in = 8'hAA;
    check("product_cleared", {16'd0, product}, 32'd0);
    if (inject) begin
      start = 1'b1;
      data_in = 8'd9;
      @(negedge clk);
      start = 1'b0;
      data_in = 8'h00;
    end
    prev_product = e.prod;
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd16, 8'd3, 1'b0);           // 48
    run_op(8'd255, 8'd255, 1'b0);        // 65025 = 0xFE01
    run_op(8'd7, 8'd0, 1'b0);            // B = 0
    run_op(8'd0, 8'd5, 1'b0);            // A = 0
    run_op(8'd5, 8'd4, 1'b1);            // stray start ignored, 20

    // Reset in the middle of a 10x10 operation.
    @(negedge clk);
    start = 1'b1;
    data_in = 8'd10;
    @(negedge clk);
    start = 1'b0;
    data_in = 8'd10;
    repeat (5) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_product = '0;
    run_op(8'd2, 8'd3, 1'b0);            // 6

    // Back-to-back; second start lands the first cycle after DONE.
    run_op(8'd3, 8'd4, 1'b0);            // 12
    run_op(8'd6, 8'd7, 1'b0);            // 42, product reads 12 until its edge 2

    repeat (3) @(negedge clk);
    check("no_pending", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
